// File: rtl/enc_pkg.sv
// Shared widths and FSM state encoding for the 8-to-3 event encoder.
package enc_pkg;

    localparam int IN_W   = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/event_encoder8x3_prio_enc8.sv
// Combinational priority encoder: picks the winning set bit of vec.
// lowest_first=1 lets bit 0 win, lowest_first=0 lets bit 7 win.
module prio_enc8
    import enc_pkg::*;
(
    input  logic [IN_W-1:0]   vec,
    input  logic              lowest_first,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Scan in the direction that leaves the winner as the last hit.
    always_comb begin
        idx = '0;
        any = |vec;
        if (lowest_first) begin
            for (int i = IN_W - 1; i >= 0; i--) begin
                if (vec[i]) idx = CODE_W'(i);
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (vec[i]) idx = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/event_encoder8x3.sv
// Event encoder: collects one-cycle event pulses in a pending register and
// presents them one at a time as a binary code over a valid/ready handshake.
module event_encoder8x3
    import enc_pkg::*;
#(
    parameter bit LOWEST_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   req,
    input  logic              clear,
    input  logic              ready_in,
    output logic [CODE_W-1:0] code_out,
    output logic              valid_out,
    output logic [IN_W-1:0]   pending,
    output logic              overflow
);

    state_e              state_q, state_d;
    logic [IN_W-1:0]     p_q, p_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                ovf_q, ovf_d;

    logic [CODE_W-1:0]   sel_idx;
    logic                sel_any;
    logic                load;
    logic [IN_W-1:0]     rm_mask;

    // Selection only looks at the registered pending vector, so a req in
    // the current cycle cannot win until the following edge.
    prio_enc8 u_prio (
        .vec          (p_q),
        .lowest_first (LOWEST_FIRST),
        .idx          (sel_idx),
        .any          (sel_any)
    );

    // Next-state: slot load, pending update, merge detection, flush.
    always_comb begin
        load    = (state_q == EMPTY) || ready_in;
        rm_mask = (load && sel_any) ? (IN_W'(1) << sel_idx) : '0;
        // A req on the bit being removed re-sets it, so it is not lost.
        p_d     = (p_q & ~rm_mask) | req;
        // Merge only when the bit stays set from before; the held code's
        // bit is already clear in p_q, so it never counts as a merge.
        ovf_d   = |(req & p_q & ~rm_mask);
        state_d = state_q;
        code_d  = code_q;
        if (load) begin
            if (sel_any) begin
                state_d = HOLD;
                code_d  = sel_idx;
            end else begin
                state_d = EMPTY;
            end
        end
        // Flush wins over any transfer; the presented code is dropped too.
        if (clear) begin
            p_d     = '0;
            ovf_d   = 1'b0;
            state_d = EMPTY;
            code_d  = code_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            p_q     <= '0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign code_out  = code_q;
    assign valid_out = (state_q == HOLD);
    assign pending   = p_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_event_encoder8x3.sv
// Directed bench for event_encoder8x3; a second instance runs highest-first.
module tb_event_encoder8x3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       clear;
    logic       ready_in;

    logic [2:0] code_lo, code_hi;
    logic       valid_lo, valid_hi;
    logic [7:0] pend_lo, pend_hi;
    logic       ovf_lo, ovf_hi;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    event_encoder8x3 #(.LOWEST_FIRST(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .clear(clear), .ready_in(ready_in),
        .code_out(code_lo), .valid_out(valid_lo), .pending(pend_lo), .overflow(ovf_lo)
    );

    event_encoder8x3 #(.LOWEST_FIRST(1'b0)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .req(req), .clear(clear), .ready_in(ready_in),
        .code_out(code_hi), .valid_out(valid_hi), .pending(pend_hi), .overflow(ovf_hi)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the low-first instance: valid, code, pending, overflow.
    task automatic chk_lo(input string tag, input logic v, input logic [2:0] c,
                          input logic [7:0] p, input logic o);
        chk({tag, ".valid"}, {7'b0, valid_lo}, {7'b0, v});
        chk({tag, ".code"},  {5'b0, code_lo},  {5'b0, c});
        chk({tag, ".pend"},  pend_lo, p);
        chk({tag, ".ovf"},   {7'b0, ovf_lo},   {7'b0, o});
    endtask

    task automatic chk_hi(input string tag, input logic v, input logic [2:0] c,
                          input logic [7:0] p);
        chk({tag, ".hvalid"}, {7'b0, valid_hi}, {7'b0, v});
        chk({tag, ".hcode"},  {5'b0, code_hi},  {5'b0, c});
        chk({tag, ".hpend"},  pend_hi, p);
    endtask

    // Advance one edge; sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; clear = 1'b0; ready_in = 1'b1;
        #2;
        chk_lo("rst", 1'b0, 3'd0, 8'h00, 1'b0);
        chk_hi("rst", 1'b0, 3'd0, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        step();
        chk_lo("idle", 1'b0, 3'd0, 8'h00, 1'b0);

        // Single event: capture, present, drain.
        req = 8'h01; step(); req = '0;
        chk_lo("s1.cap", 1'b0, 3'd0, 8'h01, 1'b0);
        step();
        chk_lo("s1.hold", 1'b1, 3'd0, 8'h00, 1'b0);
        step();
        chk_lo("s1.empty", 1'b0, 3'd0, 8'h00, 1'b0);

        // Multi-hot burst in both priority orders.
        req = 8'hA4; step(); req = '0;
        chk_lo("a4.cap", 1'b0, 3'd0, 8'hA4, 1'b0);
        chk_hi("a4.cap", 1'b0, 3'd0, 8'hA4);
        step();
        chk_lo("a4.c0", 1'b1, 3'd2, 8'hA0, 1'b0);
        chk_hi("a4.c0", 1'b1, 3'd7, 8'h24);
        step();
        chk_lo("a4.c1", 1'b1, 3'd5, 8'h80, 1'b0);
        chk_hi("a4.c1", 1'b1, 3'd5, 8'h04);
        step();
        chk_lo("a4.c2", 1'b1, 3'd7, 8'h00, 1'b0);
        chk_hi("a4.c2", 1'b1, 3'd2, 8'h00);
        step();
        chk_lo("a4.end", 1'b0, 3'd7, 8'h00, 1'b0);
        chk_hi("a4.end", 1'b0, 3'd2, 8'h00);

        // Held code 3 under backpressure; same-code req re-pends without overflow.
        req = 8'h08; step(); req = '0; ready_in = 1'b0;
        step();
        chk_lo("h3.load", 1'b1, 3'd3, 8'h00, 1'b0);
        req = 8'h08; step(); req = '0;
        chk_lo("h3.w0", 1'b1, 3'd3, 8'h08, 1'b0);
        for (int i = 1; i < 5; i++) begin
            step();
            chk_lo("h3.w", 1'b1, 3'd3, 8'h08, 1'b0);
        end
        ready_in = 1'b1; step();
        chk_lo("h3.again", 1'b1, 3'd3, 8'h00, 1'b0);
        step();
        chk_lo("h3.end", 1'b0, 3'd3, 8'h00, 1'b0);

        // req on the bit being removed keeps it pending.
        req = 8'h08; step();
        chk_lo("rm.cap", 1'b0, 3'd3, 8'h08, 1'b0);
        step(); req = '0;
        chk_lo("rm.keep", 1'b1, 3'd3, 8'h08, 1'b0);
        step();
        chk_lo("rm.next", 1'b1, 3'd3, 8'h00, 1'b0);
        step();
        chk_lo("rm.end", 1'b0, 3'd3, 8'h00, 1'b0);

        // Overflow: P[6] pending behind a held code 0, req 6 again.
        ready_in = 1'b0; req = 8'h41; step(); req = '0;
        step();
        chk_lo("ov.hold", 1'b1, 3'd0, 8'h40, 1'b0);
        req = 8'h40; step(); req = '0;
        chk_lo("ov.pulse", 1'b1, 3'd0, 8'h40, 1'b1);
        step();
        chk_lo("ov.drop", 1'b1, 3'd0, 8'h40, 1'b0);
        ready_in = 1'b1; step();
        chk_lo("ov.c6", 1'b1, 3'd6, 8'h00, 1'b0);
        step();
        chk_lo("ov.once", 1'b0, 3'd6, 8'h00, 1'b0);

        // Clear beats transfer and drops same-cycle req.
        ready_in = 1'b0; req = 8'hFF; step(); req = '0;
        step();
        chk_lo("cl.hold", 1'b1, 3'd0, 8'hFE, 1'b0);
        req = 8'h01; step();
        chk_lo("cl.full", 1'b1, 3'd0, 8'hFF, 1'b0);
        clear = 1'b1; ready_in = 1'b1; step(); clear = 1'b0; req = '0;
        chk_lo("cl.flush", 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        chk_lo("cl.quiet", 1'b0, 3'd0, 8'h00, 1'b0);

        // Asynchronous reset mid-burst.
        req = 8'hF0; step(); req = '0;
        step();
        chk_lo("ar.pre", 1'b1, 3'd4, 8'hE0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_lo("ar.now", 1'b0, 3'd0, 8'h00, 1'b0);
        chk_hi("ar.now", 1'b0, 3'd0, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        step();
        chk_lo("ar.rel", 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        chk_lo("ar.stale", 1'b0, 3'd0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
